// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the word-indexed program counter and the IF/ID
// pipeline register. Drives the PC into a combinational instruction memory and
// latches the returned word with PC+1 for decode. Decode can stall the stage,
// flush IF/ID, or redirect the PC with a branch or a jump.
//
// Parameters
//   PC_WIDTH   width of the PC and all address paths (at most 64)
//   RESET_PC   PC value loaded on reset
//   MEM_DEPTH  number of valid instruction words
//
// Ports
//   clk                in   rising-edge clock
//   rst_n              in   asynchronous active-low reset
//   stall              in   hold PC and IF/ID
//   flush              in   load a bubble into IF/ID
//   branch_taken       in   redirect to if_id_pc_plus1 + branch_offset
//   branch_offset      in   sign-extended word offset
//   jump               in   redirect to {if_id_pc_plus1[upper], jump_target}
//   jump_target        in   26-bit word index field of a J-type instruction
//   pc                 out  current PC (register output), memory address
//   instruction_in     in   memory word at pc
//   if_id_instruction  out  latched instruction (0 on a bubble)
//   if_id_pc_plus1     out  latched PC+1 of that instruction (0 on a bubble)
//   if_id_valid        out  IF/ID holds a real instruction
//   out_of_range       out  sticky: a fetch was attempted at PC >= MEM_DEPTH
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned          MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_offset,
    input  logic                 jump,
    input  logic [25:0]          jump_target,
    output logic [PC_WIDTH-1:0]  pc,
    input  logic [31:0]          instruction_in,
    output logic [31:0]          if_id_instruction,
    output logic [PC_WIDTH-1:0]  if_id_pc_plus1,
    output logic                 if_id_valid,
    output logic                 out_of_range
);

    localparam int unsigned JT_W = 26;
    localparam int unsigned JW   = (PC_WIDTH < JT_W) ? PC_WIDTH : JT_W;
    // Low JW bits come from jump_target, the rest from if_id_pc_plus1.
    localparam logic [PC_WIDTH-1:0] JUMP_MASK = PC_WIDTH'((64'(1) << JW) - 64'(1));

    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic [PC_WIDTH-1:0] r_pc_plus1;
    logic                r_valid;
    logic                r_oor;

    logic [PC_WIDTH-1:0] w_pc_next;
    logic [31:0]         w_instr_next;
    logic [PC_WIDTH-1:0] w_pc_plus1_next;
    logic                w_valid_next;
    logic                w_oor_next;

    logic                w_jump;
    logic                w_branch;
    logic                w_oor_fetch;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_jump_pc;
    logic [PC_WIDTH-1:0] w_branch_pc;

    // Redirects only count when decode holds a real instruction and is not stalled.
    assign w_jump   = jump & r_valid & ~stall;
    assign w_branch = branch_taken & r_valid & ~stall & ~jump;

    assign w_pc_inc    = r_pc + PC_WIDTH'(1);
    assign w_jump_pc   = (r_pc_plus1 & ~JUMP_MASK) | (PC_WIDTH'(jump_target) & JUMP_MASK);
    assign w_branch_pc = r_pc_plus1 + branch_offset;
    assign w_oor_fetch = 64'(r_pc) >= 64'(MEM_DEPTH);

    // Next-state for PC, IF/ID and the sticky range flag.
    always_comb begin
        w_pc_next       = w_pc_inc;
        w_instr_next    = instruction_in;
        w_pc_plus1_next = w_pc_inc;
        w_valid_next    = 1'b1;
        w_oor_next      = r_oor;

        if (stall)         w_pc_next = r_pc;
        else if (w_jump)   w_pc_next = w_jump_pc;
        else if (w_branch) w_pc_next = w_branch_pc;

        // Any non-stalled cycle at an out-of-range PC is a fetch attempt, even
        // if a flush or redirect turns the captured word into a bubble.
        if (!stall && w_oor_fetch) w_oor_next = 1'b1;

        if (flush || (!stall && (w_jump || w_branch || w_oor_fetch))) begin
            w_instr_next    = '0;
            w_pc_plus1_next = '0;
            w_valid_next    = 1'b0;
        end else if (stall) begin
            w_instr_next    = r_instr;
            w_pc_plus1_next = r_pc_plus1;
            w_valid_next    = r_valid;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
            r_oor      <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_pc_plus1 <= w_pc_plus1_next;
            r_valid    <= w_valid_next;
            r_oor      <= w_oor_next;
        end
    end

    assign pc                = r_pc;
    assign if_id_instruction = r_instr;
    assign if_id_pc_plus1    = r_pc_plus1;
    assign if_id_valid       = r_valid;
    assign out_of_range      = r_oor;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: RESET_PC = 0, memory word k = k
    logic        rst_n, stall, flush, br, jump;
    logic [31:0] off;
    logic [25:0] jt;
    logic [31:0] pc_a, ia, ifi_a, pp1_a;
    logic        v_a, oor_a;

    assign ia = pc_a;

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'd0), .MEM_DEPTH(256)) u_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_taken(br), .branch_offset(off), .jump(jump), .jump_target(jt),
        .pc(pc_a), .instruction_in(ia), .if_id_instruction(ifi_a),
        .if_id_pc_plus1(pp1_a), .if_id_valid(v_a), .out_of_range(oor_a)
    );

    // DUT B: RESET_PC = 254, words beyond 255 return garbage
    logic        rst_b, br_b;
    logic [31:0] off_b;
    logic [31:0] pc_b, ib, ifi_b, pp1_b;
    logic        v_b, oor_b;

    assign ib = (pc_b < 32'd256) ? pc_b : 32'hDEAD_BEEF;

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'd254), .MEM_DEPTH(256)) u_b (
        .clk(clk), .rst_n(rst_b), .stall(1'b0), .flush(1'b0),
        .branch_taken(br_b), .branch_offset(off_b), .jump(1'b0), .jump_target(26'd0),
        .pc(pc_b), .instruction_in(ib), .if_id_instruction(ifi_b),
        .if_id_pc_plus1(pp1_b), .if_id_valid(v_b), .out_of_range(oor_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [31:0] e_pp1, input logic e_v, input logic e_oor);
        chk({tag, ".pc"},    64'(pc_a),  64'(e_pc));
        chk({tag, ".instr"}, 64'(ifi_a), 64'(e_ins));
        chk({tag, ".pp1"},   64'(pp1_a), 64'(e_pp1));
        chk({tag, ".valid"}, 64'(v_a),   64'(e_v));
        chk({tag, ".oor"},   64'(oor_a), 64'(e_oor));
    endtask

    task automatic chk_b(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [31:0] e_pp1, input logic e_v, input logic e_oor);
        chk({tag, ".pc"},    64'(pc_b),  64'(e_pc));
        chk({tag, ".instr"}, 64'(ifi_b), 64'(e_ins));
        chk({tag, ".pp1"},   64'(pp1_b), 64'(e_pp1));
        chk({tag, ".valid"}, 64'(v_b),   64'(e_v));
        chk({tag, ".oor"},   64'(oor_b), 64'(e_oor));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br = 1'b0; jump = 1'b0;
        off = '0; jt = '0;
        rst_b = 1'b0; br_b = 1'b0; off_b = '0;
        #12;
        chk_a("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Sequential fetch: word k with pc_plus1 k+1
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_a($sformatf("seq%0d", k), 32'(k + 1), 32'(k), 32'(k + 1), 1'b1, 1'b0);
        end

        // Branch from PC 5 with offset -4 -> 2
        br = 1'b1; off = 32'(-4);
        tick();
        chk_a("br_m4_bubble", 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        br = 1'b0; off = '0;
        tick();
        chk_a("br_m4_target", 32'd3, 32'd2, 32'd3, 1'b1, 1'b0);
        for (int k = 3; k < 6; k++) begin
            tick();
            chk_a($sformatf("seq2_%0d", k), 32'(k + 1), 32'(k), 32'(k + 1), 1'b1, 1'b0);
        end

        // Branch from PC 5 with offset +10 -> 16
        br = 1'b1; off = 32'd10;
        tick();
        chk_a("br_p10_bubble", 32'd16, 32'd0, 32'd0, 1'b0, 1'b0);
        br = 1'b0; off = '0;
        tick();
        chk_a("br_p10_target", 32'd17, 32'd16, 32'd17, 1'b1, 1'b0);

        // Jump and branch together: jump wins
        jump = 1'b1; jt = 26'h40; br = 1'b1; off = 32'd5;
        tick();
        chk_a("jmp_bubble", 32'h40, 32'd0, 32'd0, 1'b0, 1'b0);
        jump = 1'b0; jt = '0; br = 1'b0; off = '0;
        tick();
        chk_a("jmp_target", 32'h41, 32'h40, 32'h41, 1'b1, 1'b0);

        // Stall with a pending branch: everything frozen
        stall = 1'b1; br = 1'b1; off = 32'(-50);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_a($sformatf("stall%0d", k), 32'h41, 32'h40, 32'h41, 1'b1, 1'b0);
        end
        // Release stall with branch held: 0x41 - 50 = 15
        stall = 1'b0;
        tick();
        chk_a("unstall_br", 32'd15, 32'd0, 32'd0, 1'b0, 1'b0);
        br = 1'b0; off = '0;
        tick();
        chk_a("unstall_tgt", 32'd16, 32'd15, 32'd16, 1'b1, 1'b0);

        // Stall + flush: PC held, IF/ID bubble
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_a("stall_flush", 32'd16, 32'd0, 32'd0, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0;
        // Jump while IF/ID holds a bubble is ignored
        jump = 1'b1; jt = 26'h99;
        tick();
        chk_a("jmp_on_bubble", 32'd17, 32'd16, 32'd17, 1'b1, 1'b0);
        jump = 1'b0; jt = '0;

        // Run to pc = 37 then reset asynchronously between edges
        for (int k = 0; k < 20; k++) tick();
        chk_a("run37", 32'd37, 32'd36, 32'd37, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        chk_a("post_rst", 32'd1, 32'd0, 32'd1, 1'b1, 1'b0);

        // Out-of-range on DUT B
        chk_b("b_reset", 32'd254, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_b = 1'b1;
        tick();
        chk_b("b_w254", 32'd255, 32'd254, 32'd255, 1'b1, 1'b0);
        tick();
        chk_b("b_w255", 32'd256, 32'd255, 32'd256, 1'b1, 1'b0);
        // Fetch at 256 while branching back to 0 (256 - 256)
        br_b = 1'b1; off_b = 32'(-256);
        tick();
        chk_b("b_oor", 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        br_b = 1'b0; off_b = '0;
        tick();
        chk_b("b_after_br", 32'd1, 32'd0, 32'd1, 1'b1, 1'b1);
        tick();
        chk_b("b_sticky", 32'd2, 32'd1, 32'd2, 1'b1, 1'b1);
        #3;
        rst_b = 1'b0;
        #1;
        chk_b("b_rst_clear", 32'd254, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
